// File: rtl/flappy_pkg.sv
// ---------------------------------------------------------------------------
// flappy_pkg
// Shared types and constants for the six-LED Flappy Bird game.
//   state_t        : game state (IDLE, PLAY, OVER)
//   BIRD_START     : altitude row the bird starts on
//   FLAP_STEP      : rows gained per flap
//   ROWS           : number of altitude rows (one LED each)
//   GAP_POSITIONS  : number of distinct pipe-gap positions
//   LFSR_TAPS      : tap mask of the 8-bit Fibonacci LFSR (taps 8,6,5,4)
// ---------------------------------------------------------------------------
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int         ROWS          = 6;
  localparam int         GAP_POSITIONS = 5;
  localparam logic [2:0] BIRD_START    = 3'd3;
  localparam logic [2:0] FLAP_STEP     = 3'd2;
  localparam logic [2:0] BIRD_TOP      = 3'(ROWS - 1);
  localparam logic [5:0] SCORE_MAX     = 6'd63;

  // Bit k set means LFSR bit k (tap k+1) feeds back.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  // Fibonacci step: shift left, XOR of the tapped bits enters at bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

  // Map the LFSR value onto a gap position 0..GAP_POSITIONS-1.
  function automatic logic [2:0] gap_from_lfsr(input logic [7:0] q);
    return 3'(q % 8'(GAP_POSITIONS));
  endfunction

  // One-hot row mask for an altitude row.
  function automatic logic [ROWS-1:0] row_bit(input logic [2:0] r);
    return ROWS'(1) << r;
  endfunction

endpackage

// File: rtl/flappy_if.sv
// ---------------------------------------------------------------------------
// flappy_if
// Board-facing user I/O of the game, bundled as one interface.
//   buttons_n : 5 active-low buttons, [0]=flap, [1]=start/restart
//   switches  : 4 static speed-select switches
//   leds_n    : 6 active-low LEDs, bit i = altitude row i (row 0 = ground)
// Modports:
//   master : the board / stimulus side (drives buttons and switches)
//   slave  : the game core (reads buttons and switches, drives LEDs)
// ---------------------------------------------------------------------------
interface flappy_if;
  import flappy_pkg::*;

  logic [4:0]      buttons_n;
  logic [3:0]      switches;
  logic [ROWS-1:0] leds_n;

  modport master (
    output buttons_n,
    output switches,
    input  leds_n
  );

  modport slave (
    input  buttons_n,
    input  switches,
    output leds_n
  );

endinterface

// File: rtl/button_edge.sv
// ---------------------------------------------------------------------------
// button_edge
// Brings one asynchronous active-low button into the clock domain and turns
// each press into a single-cycle pulse, so a held button counts once.
//   clk    : system clock
//   rst_n  : synchronous active-low reset
//   btn_n  : raw active-low button
//   press  : one-cycle pulse on the 1->0 transition of the synchronized button
// ---------------------------------------------------------------------------
module button_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  // Two-flop synchronizer, then one more flop to remember the last level.
  // Reset to the released (high) level so coming out of reset is not a press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      prev_p2 <= 1'b1;
    end else begin
      sync_p0 <= btn_n;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign press = prev_p2 & ~sync_p1;

endmodule

// File: rtl/flappy_led_top.sv
// ---------------------------------------------------------------------------
// flappy_led_top
// Minimal Flappy Bird on six active-low LEDs. The bird is one lit row; a pipe
// counts down towards the bird and must be crossed through its two-row gap.
// At game over the LEDs show the score.
//   clk_27M   : system clock, all registers on its rising edge
//   rst_n     : synchronous active-low reset
//   io.buttons_n : [0]=flap, [1]=start/restart, [4:2] unused (active-low)
//   io.switches  : tick rate, period = (switches+1)*TICK_BASE cycles
//   io.leds_n    : registered active-low LEDs, bit i = row i, row 0 = ground
// Parameters:
//   TICK_BASE  : clock cycles per unit of tick period
//   PIPE_START : pipe distance loaded when a new pipe spawns
//   LFSR_SEED  : nonzero reset value of the gap-position LFSR
// ---------------------------------------------------------------------------
module flappy_led_top #(
  parameter int         TICK_BASE  = 1_350_000,
  parameter int         PIPE_START = 15,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input logic     clk_27M,
  input logic     rst_n,
  flappy_if.slave io
);
  import flappy_pkg::*;

  // Longest period is 16*TICK_BASE cycles; the counter holds up to one less.
  localparam int         CNT_W     = $clog2(16 * TICK_BASE);
  localparam logic [3:0] PIPE_LOAD = 4'(PIPE_START);
  localparam logic [ROWS-1:0] IDLE_LEDS_N = ~row_bit(BIRD_START);

  // -------------------------------------------------------------------------
  // Input synchronization
  // -------------------------------------------------------------------------
  logic [4:0] press;
  logic       flap_press;
  logic       start_press;
  logic       unused_press;

  for (genvar i = 0; i < 5; i++) begin : g_btn
    button_edge u_btn (
      .clk   (clk_27M),
      .rst_n (rst_n),
      .btn_n (io.buttons_n[i]),
      .press (press[i])
    );
  end

  assign flap_press   = press[0];
  assign start_press  = press[1];
  assign unused_press = ^press[4:2];

  logic [3:0] sw_p0;
  logic [3:0] sw_p1;

  always_ff @(posedge clk_27M) begin
    if (!rst_n) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      sw_p0 <= io.switches;
      sw_p1 <= sw_p0;
    end
  end

  // -------------------------------------------------------------------------
  // Game state
  // -------------------------------------------------------------------------
  state_t          state;
  logic [2:0]      bird_y;
  logic [3:0]      pipe_x;
  logic [2:0]      gap_y;
  logic [5:0]      score;
  logic [CNT_W-1:0] tick_cnt;
  logic [CNT_W-1:0] tick_lim;
  logic [7:0]      lfsr;
  logic            flap_pending;
  logic [ROWS-1:0] leds_n_q;

  logic [CNT_W-1:0] lim_from_sw;
  logic             tick;
  logic [2:0]       bird_next;
  logic             ground_hit;
  logic             pipe_fail;
  logic [5:0]       score_inc;
  logic [ROWS-1:0]  lit_rows;

  // Period limit for the current synchronized switch setting.
  assign lim_from_sw = CNT_W'((int'(sw_p1) + 1) * TICK_BASE - 1);

  assign tick = (state == PLAY) && (tick_cnt == tick_lim);

  // Bird motion for the coming tick, from the pre-tick altitude.
  always_comb begin
    bird_next  = bird_y;
    ground_hit = 1'b0;
    if (flap_pending) begin
      bird_next = (bird_y >= BIRD_TOP - FLAP_STEP) ? BIRD_TOP : bird_y + FLAP_STEP;
    end else if (bird_y == 3'd0) begin
      ground_hit = 1'b1;
    end else begin
      bird_next = bird_y - 3'd1;
    end
  end

  // Collision uses the bird's updated altitude against the two gap rows.
  assign pipe_fail = (pipe_x == 4'd0) &&
                     !((bird_next == gap_y) || (bird_next == gap_y + 3'd1));

  assign score_inc = (score == SCORE_MAX) ? score : score + 6'd1;

  // Rows to light, derived from the current (registered) state.
  always_comb begin
    lit_rows = '0;
    case (state)
      IDLE: lit_rows = row_bit(BIRD_START);
      PLAY: begin
        lit_rows = row_bit(bird_y);
        if (pipe_x <= 4'd1) begin
          lit_rows = lit_rows | ~(row_bit(gap_y) | row_bit(gap_y + 3'd1));
        end
      end
      OVER:    lit_rows = score;
      default: lit_rows = '0;
    endcase
  end

  always_ff @(posedge clk_27M) begin
    if (!rst_n) begin
      state        <= IDLE;
      bird_y       <= BIRD_START;
      pipe_x       <= PIPE_LOAD;
      gap_y        <= '0;
      score        <= '0;
      tick_cnt     <= '0;
      tick_lim     <= CNT_W'(TICK_BASE - 1);
      lfsr         <= LFSR_SEED;
      flap_pending <= 1'b0;
      leds_n_q     <= IDLE_LEDS_N;
    end else begin
      // The LFSR free-runs so the gap depends on when the player acts.
      lfsr     <= lfsr_next(lfsr);
      leds_n_q <= ~lit_rows;

      case (state)
        IDLE, OVER: begin
          tick_cnt     <= '0;
          flap_pending <= 1'b0;
          if (start_press) begin
            state    <= PLAY;
            bird_y   <= BIRD_START;
            score    <= '0;
            pipe_x   <= PIPE_LOAD;
            gap_y    <= gap_from_lfsr(lfsr);
            tick_lim <= lim_from_sw;
          end
        end

        PLAY: begin
          if (tick) begin
            tick_cnt <= '0;
            tick_lim <= lim_from_sw;
            bird_y   <= bird_next;
            // A flap arriving on the tick cycle carries into the next period.
            flap_pending <= flap_press;
            if (ground_hit || pipe_fail) begin
              state <= OVER;
            end else if (pipe_x == 4'd0) begin
              score  <= score_inc;
              pipe_x <= PIPE_LOAD;
              gap_y  <= gap_from_lfsr(lfsr);
            end else begin
              pipe_x <= pipe_x - 4'd1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
            if (flap_press) begin
              flap_pending <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign io.leds_n = leds_n_q;

endmodule

// File: tb/tb_flappy_led_top.sv
// ---------------------------------------------------------------------------
// tb_flappy_led_top
// Directed stimulus with a cycle-level reference model of the game; every
// clock the model's expected LED word is queued and compared against the DUT.
// ---------------------------------------------------------------------------
module tb_flappy_led_top;

  localparam int TB_BASE = 4;
  localparam int PIPE    = 15;
  localparam int S_IDLE  = 0;
  localparam int S_PLAY  = 1;
  localparam int S_OVER  = 2;

  logic clk = 1'b0;
  logic rst_n;

  flappy_if io ();

  flappy_led_top #(
    .TICK_BASE  (TB_BASE),
    .PIPE_START (PIPE),
    .LFSR_SEED  (8'hA5)
  ) dut (
    .clk_27M (clk),
    .rst_n   (rst_n),
    .io      (io)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [5:0] exp_q[$];

  // Reference model state
  logic [4:0] mb0, mb1, mbp;
  logic [3:0] ms0, ms1;
  logic [7:0] m_lfsr;
  logic [5:0] m_leds;
  int m_st, m_by, m_px, m_gy, m_sc, m_cnt, m_lim, m_fp;
  int m_ticks = 0;

  // Test-5 measurement
  int chg[$];
  int cyc;
  int guard;
  logic [5:0] last_leds;

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_cmp++;
    n_bad++;
    $error("FAIL %s: bound expired", tag);
  endtask

  // Advance the model across one rising edge using the inputs now driven.
  task automatic model_edge();
    logic [4:0] pr;
    int lim_new, nb;
    bit gnd, pfail, tk;
    logic [5:0] lit;
    if (!rst_n) begin
      mb0 = '1; mb1 = '1; mbp = '1; ms0 = '0; ms1 = '0;
      m_st = S_IDLE; m_by = 3; m_px = PIPE; m_gy = 0; m_sc = 0;
      m_cnt = 0; m_lim = TB_BASE - 1; m_lfsr = 8'hA5; m_fp = 0;
      m_leds = 6'b110111;
      return;
    end
    pr      = mbp & ~mb1;
    lim_new = (int'(ms1) + 1) * TB_BASE - 1;
    lit = '0;
    if (m_st == S_IDLE) lit[3] = 1'b1;
    else if (m_st == S_OVER) lit = 6'(m_sc);
    else begin
      for (int r = 0; r < 6; r++)
        if (r == m_by || (m_px <= 1 && r != m_gy && r != m_gy + 1)) lit[r] = 1'b1;
    end
    m_leds = ~lit;
    tk = (m_st == S_PLAY) && (m_cnt == m_lim);
    if (m_st != S_PLAY) begin
      m_cnt = 0;
      m_fp  = 0;
      if (pr[1]) begin
        m_st = S_PLAY; m_by = 3; m_sc = 0; m_px = PIPE;
        m_gy = int'(m_lfsr) % 5; m_lim = lim_new;
      end
    end else if (tk) begin
      m_ticks++;
      gnd = 0;
      if (m_fp != 0) nb = (m_by + 2 > 5) ? 5 : m_by + 2;
      else if (m_by == 0) begin gnd = 1; nb = 0; end
      else nb = m_by - 1;
      pfail = (m_px == 0) && !(nb == m_gy || nb == m_gy + 1);
      m_by = nb; m_fp = int'(pr[0]); m_cnt = 0; m_lim = lim_new;
      if (gnd || pfail) m_st = S_OVER;
      else if (m_px == 0) begin
        m_sc = (m_sc == 63) ? 63 : m_sc + 1;
        m_px = PIPE;
        m_gy = int'(m_lfsr) % 5;
      end else m_px = m_px - 1;
    end else begin
      m_cnt++;
      if (pr[0]) m_fp = 1;
    end
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    mbp = mb1; mb1 = mb0; mb0 = io.buttons_n;
    ms1 = ms0; ms0 = io.switches;
  endtask

  task automatic step();
    model_edge();
    exp_q.push_back(m_leds);
    @(posedge clk);
    #1;
    check("leds_sb", io.leds_n, exp_q.pop_front());
  endtask

  task automatic press_btn(input int b);
    io.buttons_n[b] = 1'b0;
    repeat (3) step();
    io.buttons_n[b] = 1'b1;
    repeat (3) step();
  endtask

  task automatic wait_ticks(input int n);
    int target, budget;
    target = m_ticks + n;
    budget = 200 * n;
    while (m_ticks < target && budget > 0) begin
      step();
      budget--;
    end
    if (m_ticks < target) timeout_fail("tick_wait");
  endtask

  function automatic bit in_gap_ok(int nb, int g, bit want_pass);
    return ((nb == g) || (nb == g + 1)) == want_pass;
  endfunction

  // Plan: should the bird flap before the next tick so that, k ticks later,
  // the crossing gives the wanted outcome without touching the ground?
  function automatic bit choose_flap(int b, int k, int g, bit want_pass);
    bit ok [0:16][0:5];
    int up;
    for (int x = 0; x < 6; x++) begin
      up = (x + 2 > 5) ? 5 : x + 2;
      ok[0][x] = in_gap_ok(up, g, want_pass) || (x > 0 && in_gap_ok(x - 1, g, want_pass));
    end
    for (int kk = 1; kk <= k; kk++)
      for (int x = 0; x < 6; x++) begin
        up = (x + 2 > 5) ? 5 : x + 2;
        ok[kk][x] = ok[kk-1][up] || (x > 0 && ok[kk-1][x-1]);
      end
    if (b == 0) return 1'b1;
    if (k == 0) return !in_gap_ok(b - 1, g, want_pass);
    return !ok[k-1][b-1];
  endfunction

  initial begin
    rst_n        = 1'b0;
    io.buttons_n = 5'b11111;
    io.switches  = 4'd5;
    repeat (3) step();
    check("reset_leds", io.leds_n, 6'b110111);
    rst_n = 1'b1;

    // 1: idle for a long time
    repeat (10000) step();
    check("idle_hold", io.leds_n, 6'b110111);

    // 2: start, no flaps, bird falls to the ground
    press_btn(1);
    wait_ticks(1); step(); check("fall_y2", io.leds_n, 6'b111011);
    wait_ticks(1); step(); check("fall_y1", io.leds_n, 6'b111101);
    wait_ticks(1); step(); check("fall_y0", io.leds_n, 6'b111110);
    wait_ticks(1); step(); check("ground_over", io.leds_n, 6'b111111);

    // 3: flaps, double press counts once, saturation at row 5
    press_btn(1);
    wait_ticks(1); step(); check("restart_y2", io.leds_n, 6'b111011);
    press_btn(0); press_btn(0);
    wait_ticks(1); step(); check("double_flap_y4", io.leds_n, 6'b101111);
    press_btn(0);
    wait_ticks(1); step(); check("flap_sat_y5", io.leds_n, 6'b011111);
    press_btn(0);
    wait_ticks(1); step(); check("flap_hold_y5", io.leds_n, 6'b011111);

    // 4: fly through one gap, then miss the next pipe
    guard = 0;
    while (m_st == S_PLAY && m_sc == 0 && guard < 40) begin
      if (choose_flap(m_by, m_px, m_gy, 1'b1)) press_btn(0);
      wait_ticks(1);
      guard++;
    end
    guard = 0;
    while (m_st == S_PLAY && guard < 40) begin
      if (choose_flap(m_by, m_px, m_gy, 1'b0)) press_btn(0);
      wait_ticks(1);
      guard++;
    end
    step(); step();
    check("pipe_over_score1", io.leds_n, 6'b111110);

    // 5: speed change mid-game, start ignored in PLAY
    press_btn(1);
    io.switches = 4'd0;
    press_btn(1);
    chg.delete();
    cyc = 0;
    last_leds = io.leds_n;
    while (chg.size() < 3 && cyc < 200) begin
      step();
      cyc++;
      if (io.leds_n !== last_leds) begin
        chg.push_back(cyc);
        last_leds = io.leds_n;
      end
    end
    if (chg.size() < 3) timeout_fail("fast_ticks");
    else begin
      check_int("fast_gap_a", chg[1] - chg[0], 4);
      check_int("fast_gap_b", chg[2] - chg[1], 4);
    end
    wait_ticks(1); step();
    check("fast_over", io.leds_n, 6'b111111);

    // 6: reset during play
    io.switches = 4'd5;
    repeat (3) step();
    press_btn(1);
    repeat (5) step();
    rst_n = 1'b0;
    step();
    check("midgame_reset", io.leds_n, 6'b110111);
    rst_n = 1'b1;
    repeat (30) step();
    check("post_reset_idle", io.leds_n, 6'b110111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/flappy_led_top.md
Name: flappy_led_top

Overview:
- Top level of a minimal Flappy Bird game for the 27 MHz board, played on 6 active-low LEDs.
- Five active-low buttons and four switches are the user inputs.
- The bird's altitude is one lit LED. Pipes approach on a countdown; the score is shown on the LEDs at game over.
- All game logic advances on a game tick derived from the clock; the switches set the tick rate.

Parameters:
- TICK_BASE, 1_350_000, clock cycles per unit of tick period. Tick period = (switches+1)*TICK_BASE cycles.
- PIPE_START, 15, pipe_x value loaded when a new pipe spawns.
- LFSR_SEED, 8'hA5, nonzero reset value of the gap-position LFSR.

Ports:
- clk_27M  input  1  system clock. Every register is clocked on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- buttons_n  input  5  active-low buttons, asynchronous. [0]=flap, [1]=start/restart, [4:2] unused.
- switches  input  4  speed select, asynchronous, static-level.
- leds_n  output  6  active-low LEDs, registered. Bit i = altitude row i; row 0 = ground.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, bird_y=3, pipe_x=PIPE_START, gap_y=0, score=0, tick counter=0, lfsr=LFSR_SEED, flap_pending=0.
  - leds_n=6'b110111 from the first post-reset edge.
  - Reset asserted mid-game returns to exactly this state.
- Inputs:
  - Each button and each switch passes through a 2-FF synchronizer.
  - A press is the 1->0 transition of the synchronized button. It lasts one cycle, so a held button counts once.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, advances every cycle in every state.
- Tick generator:
  - Runs only in PLAY.
  - Pulses tick for one cycle when the counter reaches (sync switches+1)*TICK_BASE-1, then wraps to 0.
  - The switch value is resampled at each wrap.
- IDLE:
  - Display shows bird at row 3 only.
  - A start press moves to PLAY, clears the tick counter, and loads pipe_x=PIPE_START and gap_y=lfsr%5.
- PLAY:
  - A flap press sets flap_pending. Multiple presses before a tick count as one.
  - On tick, in this order, using pre-tick values:
    1. Bird:
       - If flap_pending: bird_y=min(bird_y+2,5).
       - Else if bird_y==0: ground hit -> OVER.
       - Else: bird_y-1.
       - flap_pending is cleared.
    2. Pipe:
       - If pipe_x==0: check collision with the updated bird_y. Pass if bird_y is gap_y or gap_y+1. Fail -> OVER.
       - On pass: score+1 (saturate at 63), pipe_x=PIPE_START, gap_y=lfsr%5.
       - Otherwise: pipe_x-1.
  - Ground hit and pipe fail in the same tick: OVER, score unchanged.
  - Start presses are ignored in PLAY.
- OVER:
  - leds_n = ~score[5:0].
  - A start press clears score, sets bird_y=3, and moves to PLAY with a new pipe, as from IDLE.
  - Flap presses are ignored.
- Display in PLAY:
  - Bird row is lit.
  - When pipe_x<=1, every row except gap_y and gap_y+1 is also lit (pipe wall).
- leds_n is registered: one cycle of latency after the state change.

Decomposition:
- Package flappy_pkg holds:
  - state_t enum (IDLE, PLAY, OVER);
  - constants BIRD_START=3, FLAP_STEP=2, ROWS=6, GAP_POSITIONS=5;
  - the LFSR tap mask.
- One sub-module, button_edge: 2-FF synchronizer plus falling-edge pulse. Instantiated once per button.
- The remainder lives in flappy_led_top.

Test Plan (TICK_BASE=4, switches=5, so the tick period is 24 cycles):
1. Reset, no presses for 10000 cycles -> leds_n stays 6'b110111. No state change.
2. Start press, no flaps -> bird_y goes 3,2,1,0 on successive ticks, leds_n 6'b111011, 6'b111101, 6'b111110. On the 4th tick the ground hit gives OVER and leds_n=6'b111111 (score 0).
3. In PLAY, a flap press before every tick while bird_y=3 -> bird_y goes 5 and saturates at 5 (leds_n=6'b011111). Two flap presses within one tick period -> only +2 applied.
4. Force gap_y=4 and keep bird_y at 4 or 5 through pipe_x=0 -> score=1, pipe_x reloads 15. Next pipe with bird outside its gap -> OVER, leds_n=6'b111110.
5. Change switches to 0 mid-game -> after the current period wraps, ticks occur every 4 cycles. Start pressed while in PLAY -> no effect.
6. Assert rst_n=0 for one cycle during PLAY -> next cycle state IDLE, score 0, leds_n=6'b110111.
